// File: rtl/c432_key_loader.sv
// c432_key_loader: serial key-delivery stage for the key-locked c432 netlist.
// Bits are shifted into a shadow register and committed atomically to keyinput.
// Optional feature macro: KEY_LOAD_PARITY_EN (even-parity frame check, fail counter, lockout).
module c432_key_loader #(
    parameter int unsigned KEY_W    = 8,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [KEY_W-1:0] keyinput,
    output logic             key_loaded,
    output logic             load_done,
    output logic             key_err,
    output logic             lockout
);

`ifdef KEY_LOAD_PARITY_EN
    localparam int unsigned N = KEY_W + 1;
`else
    localparam int unsigned N = KEY_W;
`endif
    localparam int unsigned CW = $clog2(KEY_W + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] KEYBITS = CW'(KEY_W);

    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_shift  = 3'd1;
    localparam logic [2:0] st_check  = 3'd2;
    localparam logic [2:0] st_loaded = 3'd3;
    localparam logic [2:0] st_lock   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             loaded_q, loaded_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             frame_ok;
    logic [2:0]       rest_state;

`ifdef KEY_LOAD_PARITY_EN
    logic       par_q, par_d;
    logic [1:0] fail_q, fail_d;
    logic [1:0] fail_inc;

    // Even parity over the key bits plus the parity bit.
    assign frame_ok = ~(^shadow_q ^ par_q);
    assign fail_inc = fail_q + 2'd1;
`else
    logic unused_cfg;

    assign frame_ok   = 1'b1;
    assign unused_cfg = ^MAX_FAIL;
`endif

    // Abort or a rejected frame falls back to whichever resting state we came from.
    assign rest_state = loaded_q ? st_loaded : st_idle;

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef KEY_LOAD_PARITY_EN
        par_d    = par_q;
        fail_d   = fail_q;
`endif
        case (state_q)
            st_idle, st_loaded: begin
                if (start) begin
                    state_d  = st_shift;
                    count_d  = '0;
                    shadow_d = '0;
`ifdef KEY_LOAD_PARITY_EN
                    par_d    = 1'b0;
`endif
                end
            end
            st_shift: begin
                if (abort) begin
                    state_d = rest_state;
                end else if (key_valid) begin
                    for (int i = 0; i < KEY_W; i++) begin
                        if (count_q == CW'(i)) shadow_d[i] = key_bit;
                    end
`ifdef KEY_LOAD_PARITY_EN
                    if (count_q == KEYBITS) par_d = key_bit;
`endif
                    // Counter saturates at the last bit rather than wrapping.
                    if (count_q == LAST) begin
                        state_d = st_check;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            st_check: begin
                if (frame_ok) begin
                    key_d    = shadow_q;
                    loaded_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = st_loaded;
`ifdef KEY_LOAD_PARITY_EN
                    fail_d   = 2'd0;
`endif
                end else begin
                    err_d = 1'b1;
`ifdef KEY_LOAD_PARITY_EN
                    fail_d = fail_inc;
                    if (fail_inc >= 2'(MAX_FAIL)) begin
                        state_d  = st_lock;
                        key_d    = '0;
                        loaded_d = 1'b0;
                    end else begin
                        state_d = rest_state;
                    end
`else
                    state_d = rest_state;
`endif
                end
            end
            st_lock: begin
                state_d = st_lock;
            end
            default: begin
                state_d = st_idle;
            end
        endcase
    end

    // State registers; reset clears the committed key immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= st_idle;
            count_q  <= '0;
            shadow_q <= '0;
            key_q    <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef KEY_LOAD_PARITY_EN
            par_q    <= 1'b0;
            fail_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef KEY_LOAD_PARITY_EN
            par_q    <= par_d;
            fail_q   <= fail_d;
`endif
        end
    end

    assign key_ready  = (state_q == st_shift);
    assign keyinput   = key_q;
    assign key_loaded = loaded_q;
    assign load_done  = done_q;
`ifdef KEY_LOAD_PARITY_EN
    assign key_err    = err_q;
    assign lockout    = (state_q == st_lock);
`else
    assign key_err    = 1'b0;
    assign lockout    = 1'b0;
`endif

endmodule

// File: tb/tb_c432_key_loader.sv
// Scoreboard bench for c432_key_loader; adapts to the KEY_LOAD_PARITY_EN build.
module tb_c432_key_loader;

`ifdef KEY_LOAD_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    typedef struct {
        logic       err;
        logic [7:0] key;
        logic       loaded;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [7:0] keyinput;
    logic       key_loaded;
    logic       load_done;
    logic       key_err;
    logic       lockout;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    c432_key_loader #(
        .KEY_W   (8),
        .MAX_FAIL(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .key_bit   (key_bit),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .keyinput  (keyinput),
        .key_loaded(key_loaded),
        .load_done (load_done),
        .key_err   (key_err),
        .lockout   (lockout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_keyinput"}, keyinput, 0);
        check({tag, "_ready"}, key_ready, 0);
        check({tag, "_loaded"}, key_loaded, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_err"}, key_err, 0);
        check({tag, "_lockout"}, lockout, 0);
    endtask

    // Offer one bit; returns #1 after the accepting edge.
    task automatic send_bit(input logic b);
        int budget = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_bit   = b;
        while (!key_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!key_ready) check("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] k, input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            send_bit(k[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    // Full frame with the expected CHECK outcome supplied by the caller.
    task automatic send_frame(input logic [7:0] k, input logic p, input int gap,
                              input logic exp_err, input logic [7:0] exp_key,
                              input logic exp_loaded);
        exp_t  e;
        logic  b;
        start_pulse();
        check("ready_after_start", key_ready, 1);
        for (int i = 0; i < NBITS; i++) begin
            b = (i < 8) ? k[i] : p;
            if (i == NBITS - 1) begin
                e.err = exp_err;
                e.key = exp_key;
                e.loaded = exp_loaded;
                sb.push_back(e);
            end
            send_bit(b);
            if (i != NBITS - 1) repeat (gap) @(negedge clk);
        end
        check("ready_in_check", key_ready, 0);
        check("no_early_event", {load_done, key_err}, 0);
        @(posedge clk);
        #1;
        check("event_latency", exp_err ? key_err : load_done, 1);
        check("key_after_2_edges", keyinput, exp_key);
    endtask

    // Monitor: every done/err pulse is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (load_done || key_err)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_event", {load_done, key_err}, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind", {load_done, key_err}, e.err ? 2'b01 : 2'b10);
                    check("sb_key", keyinput, e.key);
                    check("sb_loaded", key_loaded, e.loaded);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_outputs("reset");
        do_reset();
        check_reset_outputs("after_reset");

        // Good frame 0xA5, parity 0.
        send_frame(8'hA5, 1'b0, 0, 1'b0, 8'hA5, 1'b1);
        check("a5_loaded", key_loaded, 1);

`ifdef KEY_LOAD_PARITY_EN
        // Bad parity while loaded keeps the old key.
        send_frame(8'h3C, 1'b1, 0, 1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        check("bad_keeps_key", keyinput, 8'hA5);
        check("bad_keeps_loaded", key_loaded, 1);
        check("bad_no_lockout", lockout, 0);

        // Three consecutive bad frames from IDLE lock the loader.
        do_reset();
        send_frame(8'h3C, 1'b1, 0, 1'b1, 8'h00, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 1'b1, 8'h00, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 1'b1, 8'h00, 1'b0);
        check("lockout_set", lockout, 1);
        check("lockout_key", keyinput, 0);
        check("lockout_ready", key_ready, 0);
        // Good frame attempt is ignored.
        @(negedge clk);
        start = 1'b1;
        key_valid = 1'b1;
        key_bit = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("lockout_ignores_ready", key_ready, 0);
        end
        start = 1'b0;
        key_valid = 1'b0;
        check("lockout_stays", lockout, 1);
        check("lockout_key_zero", keyinput, 0);
        check("lockout_not_loaded", key_loaded, 0);
        do_reset();
        check_reset_outputs("lockout_cleared");
`endif

        // Abort after 4 bits with a valid bit offered on the abort cycle.
        do_reset();
        start_pulse();
        send_bits(8'hFF, 4, 0);
        @(negedge clk);
        abort = 1'b1;
        key_valid = 1'b1;
        key_bit = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        key_valid = 1'b0;
        check("abort_to_idle_ready", key_ready, 0);
        check("abort_idle_loaded", key_loaded, 0);
        check("abort_idle_key", keyinput, 0);
        // Full frame with 3-cycle valid gaps.
        send_frame(8'h3C, 1'b0, 3, 1'b0, 8'h3C, 1'b1);

        // Abort from LOADED returns to LOADED; abort outside SHIFT does nothing.
        start_pulse();
        send_bits(8'h00, 2, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("abort_loaded_ready", key_ready, 0);
        check("abort_loaded_level", key_loaded, 1);
        check("abort_loaded_key", keyinput, 8'h3C);
        @(negedge clk);
        abort = 1'b0;

        // Back-to-back reload: start right after load_done.
        send_frame(8'hA5, 1'b0, 0, 1'b0, 8'hA5, 1'b1);
        send_frame(8'h81, 1'b0, 0, 1'b0, 8'h81, 1'b1);

        // Reset mid-frame clears the key immediately.
        send_frame(8'hA5, 1'b0, 0, 1'b0, 8'hA5, 1'b1);
        start_pulse();
        send_bits(8'h0F, 5, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_frame_reset");
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h3C, 1'b0, 1, 1'b0, 8'h3C, 1'b1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("final_lockout", lockout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c432_key_loader.md
# c432_key_loader

Serial key-delivery stage that sits directly upstream of the key-locked c432 netlist and drives its eight `keyinputN` ports. Key bits arrive one per handshake from the key store or tester. An optional parity check validates each frame. The key is assembled in a shadow register and committed atomically, so the locked netlist never sees a partial key. Repeated bad frames trigger a permanent lockout that zeroes the key until reset.

## Interface

**Parameters**
- `KEY_W`, default 8: number of key bits. Bit i drives `keyinput<i>`.
- `MAX_FAIL`, default 3: count of consecutive failed frames that triggers lockout. Range 1..3.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a new key load.
- `abort`, input, 1: discard the frame currently being shifted in.
- `key_bit`, input, 1: serial key data, LSB first.
- `key_valid`, input, 1: `key_bit` is valid.
- `key_ready`, output, 1: loader accepts a bit this cycle.
- `keyinput`, output, `KEY_W`: committed key, wired to `keyinput0..7` of the locked netlist.
- `key_loaded`, output, 1: level; a committed key is present.
- `load_done`, output, 1: one-cycle pulse on commit.
- `key_err`, output, 1: one-cycle pulse on parity failure.
- `lockout`, output, 1: level; permanent lockout state.

## Operation

**States**
- IDLE: no key loaded.
- SHIFT: receiving a frame.
- CHECK: validating the frame.
- LOADED: a key is committed.
- LOCKOUT: terminal until reset.

**Frame**
- Frame length N = `KEY_W` + 1 with parity enabled, `KEY_W` without.
- Bits 0..`KEY_W`-1 are the key, LSB first. Bit `KEY_W` is the parity bit.

**Transitions and rules**
- IDLE or LOADED with `start`=1 goes to SHIFT. The bit counter and shadow register are cleared.
- `start` is ignored in SHIFT, CHECK and LOCKOUT.
- SHIFT: `key_ready`=1. A bit is accepted on an edge with `key_valid && key_ready && !abort`. It goes to shadow[count], and count increments.
- SHIFT with `abort`=1 returns to the prior resting state (IDLE or LOADED). The bit offered that cycle is dropped. The fail counter is unchanged.
- When the N-th bit is accepted, the next state is CHECK.
- CHECK, pass: `keyinput` takes the shadow value, `key_loaded`=1, `load_done` pulses, the fail counter clears, and the next state is LOADED.
- CHECK, fail: `key_err` pulses and the fail counter increments.
  - If the counter reaches `MAX_FAIL`, go to LOCKOUT.
  - Otherwise return to the prior resting state. `keyinput` and `key_loaded` are unchanged.
- The parity check passes when the XOR of all N bits is 0 (even parity).
- LOCKOUT: `keyinput`=0, `key_loaded`=0, `key_ready`=0, `lockout`=1. All inputs are ignored.
- While LOADED, a reload keeps the old key on `keyinput` until the new frame commits.

## Timing

**Reset values:** state IDLE; `keyinput`=0; `key_ready`=0; `key_loaded`=0; `load_done`=0; `key_err`=0; `lockout`=0. The shadow register, counter and fail count are also 0.

**Latency and handshake**
- `start` sampled at edge E gives `key_ready`=1 from E onward (state SHIFT).
- `key_ready` is a registered-state decode. It does not depend combinationally on `key_valid`.
- Idle cycles with `key_valid`=0 are allowed anywhere in the frame and do not change the count.
- If the last bit is accepted at edge E, the state is CHECK for one cycle and `key_ready`=0.
- At edge E+1, `keyinput`, `key_loaded` and `load_done` (or `key_err`) update.
- Last bit to key visible: 2 edges.
- Minimum back-to-back reload: `start` in the cycle after `load_done`.

**Boundary conditions**
- `abort` together with a valid handshake: `abort` wins.
- `abort` outside SHIFT: no effect.
- Reset mid-frame or in CHECK: the key is cleared immediately. It is not held.
- The bit counter never wraps. It is compared against N−1 exactly.

## Configuration

- `KEY_LOAD_PARITY_EN` defined:
  - Frames are `KEY_W`+1 bits with the parity check.
  - Failures are counted, and lockout is reachable.
- `KEY_LOAD_PARITY_EN` undefined:
  - Frames are `KEY_W` bits.
  - CHECK always passes.
  - `key_err` and `lockout` are tied to 0.
  - The fail counter is removed.

## Test plan

All scenarios run with `KEY_LOAD_PARITY_EN` defined, `KEY_W`=8 and `MAX_FAIL`=3.

1. Good frame: after reset, `start`, then bits 1,0,1,0,0,1,0,1 followed by parity 0 (key 0xA5). Required: `keyinput`=0xA5 exactly 2 edges after the last bit, one `load_done` pulse, `key_loaded`=1.
2. Bad parity while loaded: with 0xA5 loaded, send frame 0x3C with parity 1. Required: one `key_err` pulse, `keyinput` stays 0xA5, state returns to LOADED.
3. Lockout: from IDLE, send three consecutive bad-parity frames. Required: `lockout`=1 after the third CHECK, `keyinput`=0, `key_ready`=0. A subsequent good frame is ignored until `rst`.
4. Abort and backpressure: `abort` after 4 bits (with `key_valid` high on the abort cycle), then a full 0x3C frame with parity 0 and 3-cycle `key_valid` gaps. Required: `keyinput`=0x3C and no `key_err`.
5. Reset mid-frame: assert `rst` after 5 bits with 0xA5 loaded. Required: all outputs at reset values immediately; a new frame loads cleanly.
6. Build without the macro: send 8 bits of 0x81. Required: `keyinput`=0x81 after 2 edges; `key_err` is never asserted.
